tictactoe_game_ctrl: RTL and testbench
======================================

# tictactoe_game_ctrl

Game sequencer for the tic-tac-toe FPGA design. Owns the 3×3 board register and alternates turns between the human input path and the CPU move engine, which it drives over a request/acknowledge handshake. After every placement it checks for a win or draw, and it latches the difficulty used by the move engine for the whole game.

## Interface
Parameters:
- HUMAN_FIRST, 1: 1 means the human moves first after `start`; 0 means the CPU moves first.
- TIMEOUT_CYCLES, 255: CPU watchdog limit in clock cycles. Only used with `CPU_TIMEOUT_EN`.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  begins a new game. Honoured only in IDLE or DONE.
- difficulty  in  2  0 facil, 1 medio, 2 dificil, 3 treated as dificil. Sampled when `start` is accepted.
- player_valid  in  1  human move offered.
- player_cell  in  4  cell index 0..8, where index = row*3+col.
- player_ready  out  1  controller accepts a human move this cycle.
- cpu_req  out  1  asks the move engine for a move.
- cpu_ack  in  1  move engine presents `cpu_cell`.
- cpu_cell  in  4  CPU cell index 0..8.
- cpu_difficulty  out  2  difficulty latched for the move engine.
- board  out  18  cell i is `board[2i+1:2i]`.
- move_count  out  4  placements so far, 0..9.
- game_over  out  1  high while in DONE.
- winner  out  2  winning cell code; CELL_EMPTY means none or draw.
- err  out  1  one-cycle pulse on each rejected move.

## Operation
- Cell codes: CELL_CPU=2'd0, CELL_HUMAN=2'd1, CELL_EMPTY=2'd2. Code 2'd3 is never written.
- FSM states: IDLE, HUMAN_TURN, CPU_REQ, CHECK, DONE.
- IDLE/DONE on `start`:
  - board set to all EMPTY, move_count cleared, winner set to EMPTY;
  - `cpu_difficulty` latched from `difficulty`;
  - next state is HUMAN_TURN if HUMAN_FIRST, else CPU_REQ.
- HUMAN_TURN:
  - `player_ready`=1;
  - the move is accepted on `player_valid & player_ready`.
- CPU_REQ:
  - `cpu_req`=1 until `cpu_ack`;
  - `cpu_cell` is sampled on the `cpu_ack` cycle.
- A move is legal when the cell is ≤8 and the board holds EMPTY there.
  - Legal move: write the mover's code, increment move_count, go to CHECK.
  - Illegal move: pulse `err`, leave the board unchanged, stay in the same state. The human re-offers; in CPU_REQ `cpu_req` stays high.
- CHECK evaluates the 8 lines (3 rows, 3 columns, 2 diagonals) on the registered board. The first matching case applies:
  - a line of three equal non-EMPTY codes: winner = that code, go to DONE;
  - move_count==9: draw, winner stays EMPTY, go to DONE;
  - otherwise: the turn passes to the other side (HUMAN_TURN ↔ CPU_REQ).
- DONE: `game_over`=1; board and winner hold until `start`.
- `start` is ignored in HUMAN_TURN, CPU_REQ and CHECK. `difficulty` changes mid-game are ignored.

## Timing
- Reset values:
  - state IDLE, board 18'h2AAAA (all EMPTY), move_count 0;
  - winner 2'd2, cpu_difficulty 0;
  - game_over, player_ready, cpu_req and err all 0.
- All outputs are registered or decoded from state, with no combinational path from inputs.
- Human move: the board updates at the edge after the accept, CHECK follows for one cycle, and the next turn state is entered on the following edge. `player_ready` therefore drops for exactly one cycle between turns.
- `cpu_req` asserts the cycle after entering CPU_REQ and deasserts the cycle after an accepted `cpu_ack`. A `cpu_ack` arriving outside CPU_REQ is ignored.
- `err` is high for exactly one cycle, the cycle after the rejected offer.
- Reset asserted mid-game drives the block asynchronously to IDLE with all outputs at their reset values. A pending `cpu_ack` is dropped.

## Configuration
- Macro `TICTACTOE_CPU_TIMEOUT_EN`.
- Defined:
  - an 8-bit watchdog counts cycles spent in CPU_REQ;
  - when it reaches TIMEOUT_CYCLES without an accepted ack, the controller places CELL_CPU in the lowest-index EMPTY cell, pulses `err`, and goes to CHECK;
  - the counter clears on entry to CPU_REQ.
- Undefined: no watchdog; CPU_REQ waits indefinitely.

## Structure
- Package `tictactoe_pkg` holds:
  - the cell codes and the difficulty codes (FACIL=0, MEDIO=1, DIFICIL=2);
  - the FSM state enum;
  - the 8 win-line cell-index triples as constants.
- Sub-module `tictactoe_win_check` is purely combinational: board in, `win` plus `win_code` out. It is instantiated once and sampled in CHECK.

## Test plan
- Reset, then `start` with difficulty=1 and HUMAN_FIRST=1 → board=18'h2AAAA, cpu_difficulty=1, player_ready=1 two cycles later.
- Human plays 0, 1, 2; CPU acks 3, then 4 → after the human's third move: game_over=1, winner=2'd1, move_count=5.
- Human offers cell 4 when it is occupied, then cell 9 → two `err` pulses, board unchanged, still in HUMAN_TURN.
- Full 9-move game with no line → game_over=1, winner=2'd2, move_count=9.
- CPU acks an occupied cell → `err` pulse, `cpu_req` remains high; with TICTACTOE_CPU_TIMEOUT_EN and TIMEOUT_CYCLES=4 and no ack → CPU code placed in the lowest EMPTY cell 5 cycles after entering CPU_REQ.
- Reset asserted while `cpu_req`=1 → cpu_req=0 and board=18'h2AAAA with no clock edge; `start` during play → no effect.

Source files
------------

// File: rtl/tictactoe_pkg.sv
// Shared definitions for the tic-tac-toe game controller: cell and difficulty
// codes, the sequencer state enum, the eight win lines and board helpers.
package tictactoe_pkg;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;

    // Cell occupancy codes; 2'd3 is never written to the board.
    localparam logic [1:0] CELL_CPU   = 2'd0;
    localparam logic [1:0] CELL_HUMAN = 2'd1;
    localparam logic [1:0] CELL_EMPTY = 2'd2;

    // Move-engine difficulty codes.
    localparam logic [1:0] FACIL   = 2'd0;
    localparam logic [1:0] MEDIO   = 2'd1;
    localparam logic [1:0] DIFICIL = 2'd2;

    localparam logic [17:0] BOARD_EMPTY = 18'h2AAAA;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        HUMAN_TURN = 3'd1,
        CPU_REQ    = 3'd2,
        CHECK      = 3'd3,
        DONE       = 3'd4
    } state_e;

    // Cell-index triples: three rows, three columns, two diagonals.
    localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // A move is legal only on an in-range cell that is still empty.
    function automatic logic cell_is_free(input logic [17:0] board, input logic [3:0] idx);
        logic free;
        free = 1'b0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (idx == 4'(i) && board[2*i +: 2] == CELL_EMPTY) begin
                free = 1'b1;
            end
        end
        return free;
    endfunction

    function automatic logic [17:0] set_cell(input logic [17:0] board, input logic [3:0] idx,
                                             input logic [1:0] code);
        logic [17:0] r;
        r = board;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (idx == 4'(i)) begin
                r[2*i +: 2] = code;
            end
        end
        return r;
    endfunction

    // Lowest-index empty cell; scanning downwards lets the lowest match win.
    function automatic logic [3:0] first_empty(input logic [17:0] board);
        logic [3:0] r;
        r = 4'd0;
        for (int i = NUM_CELLS - 1; i >= 0; i--) begin
            if (board[2*i +: 2] == CELL_EMPTY) begin
                r = 4'(i);
            end
        end
        return r;
    endfunction

    // Code 3 is not a level of its own; the engine sees it as dificil.
    function automatic logic [1:0] norm_difficulty(input logic [1:0] d);
        return (d == 2'd3) ? DIFICIL : d;
    endfunction

endpackage

// File: rtl/tictactoe_win_check.sv
// Combinational three-in-a-row detector over the 3x3 board.
module tictactoe_win_check
    import tictactoe_pkg::*;
(
    input  logic [17:0] board_i,
    output logic        win_o,
    output logic [1:0]  win_code_o
);

    logic [NUM_LINES-1:0] line_hit;
    logic [1:0]           line_code [NUM_LINES];

    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
            logic [1:0] cell_a;
            logic [1:0] cell_b;
            logic [1:0] cell_c;
            assign cell_a        = board_i[2*WIN_LINES[gi][0] +: 2];
            assign cell_b        = board_i[2*WIN_LINES[gi][1] +: 2];
            assign cell_c        = board_i[2*WIN_LINES[gi][2] +: 2];
            assign line_hit[gi]  = (cell_a == cell_b) && (cell_b == cell_c) && (cell_a != CELL_EMPTY);
            assign line_code[gi] = cell_a;
        end
    endgenerate

    // Report the code of the lowest-numbered completed line.
    always_comb begin
        win_o      = |line_hit;
        win_code_o = CELL_EMPTY;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (line_hit[i]) begin
                win_code_o = line_code[i];
            end
        end
    end

endmodule

// File: rtl/tictactoe_game_ctrl.sv
// Tic-tac-toe game sequencer: owns the board, alternates human and CPU turns,
// and detects win/draw after every placement.
// Optional CPU watchdog enabled by defining TICTACTOE_CPU_TIMEOUT_EN.
module tictactoe_game_ctrl
    import tictactoe_pkg::*;
#(
    parameter int HUMAN_FIRST    = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [1:0]  difficulty_i,
    input  logic        player_valid_i,
    input  logic [3:0]  player_cell_i,
    output logic        player_ready_o,
    output logic        cpu_req_o,
    input  logic        cpu_ack_i,
    input  logic [3:0]  cpu_cell_i,
    output logic [1:0]  cpu_difficulty_o,
    output logic [17:0] board_o,
    output logic [3:0]  move_count_o,
    output logic        game_over_o,
    output logic [1:0]  winner_o,
    output logic        err_o
);

    state_e      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic [3:0]  count_q, count_d;
    logic [1:0]  winner_q, winner_d;
    logic [1:0]  diff_q, diff_d;
    logic        err_q, err_d;
    logic        last_human_q, last_human_d;
`ifdef TICTACTOE_CPU_TIMEOUT_EN
    logic [7:0]  wdog_q, wdog_d;
`endif

    logic        win;
    logic [1:0]  win_code;

    tictactoe_win_check u_win_check (
        .board_i    (board_q),
        .win_o      (win),
        .win_code_o (win_code)
    );

    // State and datapath registers; reset abandons any game in progress.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            board_q      <= BOARD_EMPTY;
            count_q      <= 4'd0;
            winner_q     <= CELL_EMPTY;
            diff_q       <= FACIL;
            err_q        <= 1'b0;
            last_human_q <= 1'b0;
`ifdef TICTACTOE_CPU_TIMEOUT_EN
            wdog_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            count_q      <= count_d;
            winner_q     <= winner_d;
            diff_q       <= diff_d;
            err_q        <= err_d;
            last_human_q <= last_human_d;
`ifdef TICTACTOE_CPU_TIMEOUT_EN
            wdog_q       <= wdog_d;
`endif
        end
    end

    // Next-state logic: move legality, placement, win/draw evaluation.
    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        count_d      = count_q;
        winner_d     = winner_q;
        diff_d       = diff_q;
        err_d        = 1'b0;
        last_human_d = last_human_q;
`ifdef TICTACTOE_CPU_TIMEOUT_EN
        wdog_d       = wdog_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    board_d  = BOARD_EMPTY;
                    count_d  = 4'd0;
                    winner_d = CELL_EMPTY;
                    diff_d   = norm_difficulty(difficulty_i);
                    state_d  = (HUMAN_FIRST != 0) ? HUMAN_TURN : CPU_REQ;
`ifdef TICTACTOE_CPU_TIMEOUT_EN
                    wdog_d   = 8'd0;
`endif
                end
            end
            HUMAN_TURN: begin
                if (player_valid_i) begin
                    if (cell_is_free(board_q, player_cell_i)) begin
                        board_d      = set_cell(board_q, player_cell_i, CELL_HUMAN);
                        count_d      = count_q + 4'd1;
                        last_human_d = 1'b1;
                        state_d      = CHECK;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CPU_REQ: begin
                if (cpu_ack_i && cell_is_free(board_q, cpu_cell_i)) begin
                    board_d      = set_cell(board_q, cpu_cell_i, CELL_CPU);
                    count_d      = count_q + 4'd1;
                    last_human_d = 1'b0;
                    state_d      = CHECK;
`ifdef TICTACTOE_CPU_TIMEOUT_EN
                end else if (wdog_q == 8'(TIMEOUT_CYCLES)) begin
                    // Engine stalled: play the lowest free cell on its behalf.
                    board_d      = set_cell(board_q, first_empty(board_q), CELL_CPU);
                    count_d      = count_q + 4'd1;
                    last_human_d = 1'b0;
                    err_d        = 1'b1;
                    state_d      = CHECK;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                    err_d  = cpu_ack_i;
                end
`else
                end else begin
                    err_d = cpu_ack_i;
                end
`endif
            end
            CHECK: begin
                if (win) begin
                    winner_d = win_code;
                    state_d  = DONE;
                end else if (count_q == 4'd9) begin
                    state_d = DONE;
                end else begin
                    state_d = last_human_q ? CPU_REQ : HUMAN_TURN;
                end
`ifdef TICTACTOE_CPU_TIMEOUT_EN
                wdog_d = 8'd0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign player_ready_o   = (state_q == HUMAN_TURN);
    assign cpu_req_o        = (state_q == CPU_REQ);
    assign game_over_o      = (state_q == DONE);
    assign cpu_difficulty_o = diff_q;
    assign board_o          = board_q;
    assign move_count_o     = count_q;
    assign winner_o         = winner_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_tictactoe_game_ctrl.sv
// Directed testbench for tictactoe_game_ctrl.
// With TICTACTOE_CPU_TIMEOUT_EN defined the watchdog limit is set to 4.
module tb_tictactoe_game_ctrl;

`ifdef TICTACTOE_CPU_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  difficulty = 2'd0;
    logic        pvalid = 1'b0;
    logic [3:0]  pcell = 4'd0;
    logic        pready;
    logic        cpu_req;
    logic        cpu_ack = 1'b0;
    logic [3:0]  cpu_cell = 4'd0;
    logic [1:0]  cpu_diff;
    logic [17:0] board;
    logic [3:0]  mcount;
    logic        game_over;
    logic [1:0]  winner;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    tictactoe_game_ctrl #(.HUMAN_FIRST(1), .TIMEOUT_CYCLES(TMO)) dut (
        .clock_i          (clk),
        .reset_i          (rst),
        .start_i          (start),
        .difficulty_i     (difficulty),
        .player_valid_i   (pvalid),
        .player_cell_i    (pcell),
        .player_ready_o   (pready),
        .cpu_req_o        (cpu_req),
        .cpu_ack_i        (cpu_ack),
        .cpu_cell_i       (cpu_cell),
        .cpu_difficulty_o (cpu_diff),
        .board_o          (board),
        .move_count_o     (mcount),
        .game_over_o      (game_over),
        .winner_o         (winner),
        .err_o            (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!pready && n < 20) begin tick(); n++; end
        vectors++;
        if (pready !== 1'b1) begin miscompares++; $display("FAIL wait_ready: player_ready=%b required 1 within 20 cycles", pready); end
    endtask

    task automatic wait_cpu_req();
        int n = 0;
        while (!cpu_req && n < 20) begin tick(); n++; end
        vectors++;
        if (cpu_req !== 1'b1) begin miscompares++; $display("FAIL wait_cpu_req: cpu_req=%b required 1 within 20 cycles", cpu_req); end
    endtask

    task automatic human_move(input logic [3:0] c);
        wait_ready();
        pvalid = 1'b1; pcell = c;
        tick();
        pvalid = 1'b0;
        $display("human move cell %0d -> board %h count %0d", c, board, mcount);
    endtask

    task automatic cpu_move(input logic [3:0] c);
        wait_cpu_req();
        cpu_ack = 1'b1; cpu_cell = c;
        tick();
        cpu_ack = 1'b0;
        $display("cpu move cell %0d -> board %h count %0d", c, board, mcount);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        $display("reset: board %h count %0d winner %0d", board, mcount, winner);
        vectors++; if (board !== 18'h2AAAA) begin miscompares++; $display("FAIL reset_board: got %h want %h", board, 18'h2AAAA); end
        vectors++; if (mcount !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", mcount); end
        vectors++; if (winner !== 2'd2) begin miscompares++; $display("FAIL reset_winner: got %0d want 2", winner); end
        vectors++; if (cpu_diff !== 2'd0) begin miscompares++; $display("FAIL reset_diff: got %0d want 0", cpu_diff); end
        vectors++; if ({game_over, pready, cpu_req, err} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags: got %b want 0000", {game_over, pready, cpu_req, err}); end
    endtask

    task automatic test_start();
        difficulty = 2'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        $display("start: ready %b diff %0d board %h", pready, cpu_diff, board);
        vectors++; if (pready !== 1'b1) begin miscompares++; $display("FAIL start_ready: got %b want 1", pready); end
        vectors++; if (cpu_diff !== 2'd1) begin miscompares++; $display("FAIL start_diff: got %0d want 1", cpu_diff); end
        vectors++; if (board !== 18'h2AAAA) begin miscompares++; $display("FAIL start_board: got %h want %h", board, 18'h2AAAA); end
    endtask

    task automatic test_ignored_inputs();
        difficulty = 2'd2; start = 1'b1;
        tick();
        start = 1'b0; difficulty = 2'd0;
        cpu_ack = 1'b1; cpu_cell = 4'd5;
        tick();
        cpu_ack = 1'b0;
        $display("ignored start/ack: ready %b diff %0d board %h", pready, cpu_diff, board);
        vectors++; if (pready !== 1'b1) begin miscompares++; $display("FAIL ign_ready: got %b want 1", pready); end
        vectors++; if (cpu_diff !== 2'd1) begin miscompares++; $display("FAIL ign_diff: got %0d want 1", cpu_diff); end
        vectors++; if (board !== 18'h2AAAA || mcount !== 4'd0) begin miscompares++; $display("FAIL ign_board: got %h/%0d want 2aaaa/0", board, mcount); end
    endtask

    task automatic test_human_win();
        human_move(4'd0);
        vectors++; if (board !== 18'h2AAA9) begin miscompares++; $display("FAIL hw_board1: got %h want %h", board, 18'h2AAA9); end
        vectors++; if (pready !== 1'b0 || cpu_req !== 1'b0) begin miscompares++; $display("FAIL hw_check_gap: got ready %b req %b want 0 0", pready, cpu_req); end
        tick();
        vectors++; if (cpu_req !== 1'b1) begin miscompares++; $display("FAIL hw_req: got %b want 1", cpu_req); end
        cpu_move(4'd3);
        vectors++; if (board !== 18'h2AA29 || mcount !== 4'd2) begin miscompares++; $display("FAIL hw_board2: got %h/%0d want 2aa29/2", board, mcount); end
        vectors++; if (cpu_req !== 1'b0) begin miscompares++; $display("FAIL hw_req_drop: got %b want 0", cpu_req); end
        human_move(4'd1);
        vectors++; if (board !== 18'h2AA25) begin miscompares++; $display("FAIL hw_board3: got %h want %h", board, 18'h2AA25); end
        cpu_move(4'd4);
        vectors++; if (board !== 18'h2A825 || mcount !== 4'd4) begin miscompares++; $display("FAIL hw_board4: got %h/%0d want 2a825/4", board, mcount); end
    endtask

    task automatic test_illegal_human();
        wait_ready();
        pvalid = 1'b1; pcell = 4'd4;
        tick();
        $display("human offers occupied 4: err %b board %h", err, board);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL ill_err_occ: got %b want 1", err); end
        vectors++; if (board !== 18'h2A825) begin miscompares++; $display("FAIL ill_board: got %h want %h", board, 18'h2A825); end
        pcell = 4'd9;
        tick();
        pvalid = 1'b0;
        $display("human offers cell 9: err %b board %h", err, board);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL ill_err_range: got %b want 1", err); end
        tick();
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL ill_err_clear: got %b want 0", err); end
        vectors++; if (pready !== 1'b1 || mcount !== 4'd4 || board !== 18'h2A825) begin miscompares++; $display("FAIL ill_state: got ready %b count %0d board %h want 1 4 2a825", pready, mcount, board); end
        human_move(4'd2);
        vectors++; if (board !== 18'h2A815 || mcount !== 4'd5) begin miscompares++; $display("FAIL win_board: got %h/%0d want 2a815/5", board, mcount); end
        tick();
        $display("win: game_over %b winner %0d", game_over, winner);
        vectors++; if (game_over !== 1'b1) begin miscompares++; $display("FAIL win_over: got %b want 1", game_over); end
        vectors++; if (winner !== 2'd1) begin miscompares++; $display("FAIL win_winner: got %0d want 1", winner); end
    endtask

    task automatic test_draw();
        difficulty = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
        $display("restart: over %b board %h winner %0d diff %0d", game_over, board, winner, cpu_diff);
        vectors++; if (game_over !== 1'b0 || board !== 18'h2AAAA || winner !== 2'd2 || mcount !== 4'd0) begin miscompares++; $display("FAIL restart: got over %b board %h winner %0d count %0d want 0 2aaaa 2 0", game_over, board, winner, mcount); end
        vectors++; if (cpu_diff !== 2'd2) begin miscompares++; $display("FAIL restart_diff: got %0d want 2", cpu_diff); end
        human_move(4'd0);
        wait_cpu_req();
        cpu_ack = 1'b1; cpu_cell = 4'd0;
        tick();
        cpu_ack = 1'b0;
        $display("cpu acks occupied 0: err %b req %b board %h", err, cpu_req, board);
        vectors++; if (err !== 1'b1 || cpu_req !== 1'b1) begin miscompares++; $display("FAIL cpu_ill: got err %b req %b want 1 1", err, cpu_req); end
        vectors++; if (board !== 18'h2AAA9) begin miscompares++; $display("FAIL cpu_ill_board: got %h want %h", board, 18'h2AAA9); end
        cpu_move(4'd1); human_move(4'd2); cpu_move(4'd4); human_move(4'd3);
        cpu_move(4'd5); human_move(4'd7); cpu_move(4'd6); human_move(4'd8);
        tick();
        $display("draw: over %b winner %0d count %0d board %h", game_over, winner, mcount, board);
        vectors++; if (game_over !== 1'b1 || winner !== 2'd2) begin miscompares++; $display("FAIL draw_result: got over %b winner %0d want 1 2", game_over, winner); end
        vectors++; if (mcount !== 4'd9 || board !== 18'h14051) begin miscompares++; $display("FAIL draw_board: got %0d/%h want 9/14051", mcount, board); end
    endtask

    task automatic test_cpu_wait();
        difficulty = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        human_move(4'd0);
        tick();
`ifdef TICTACTOE_CPU_TIMEOUT_EN
        repeat (4) tick();
        vectors++; if (board !== 18'h2AAA9 || cpu_req !== 1'b1) begin miscompares++; $display("FAIL tmo_early: got board %h req %b want 2aaa9 1", board, cpu_req); end
        tick();
        $display("watchdog: board %h err %b count %0d", board, err, mcount);
        vectors++; if (board !== 18'h2AAA1 || err !== 1'b1 || mcount !== 4'd2) begin miscompares++; $display("FAIL tmo_place: got board %h err %b count %0d want 2aaa1 1 2", board, err, mcount); end
`else
        repeat (30) tick();
        $display("cpu stall: req %b board %h", cpu_req, board);
        vectors++; if (cpu_req !== 1'b1 || board !== 18'h2AAA9 || err !== 1'b0) begin miscompares++; $display("FAIL stall_wait: got req %b board %h err %b want 1 2aaa9 0", cpu_req, board, err); end
`endif
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; tick(); rst = 1'b0; tick();
        difficulty = 2'd3; start = 1'b1;
        tick();
        start = 1'b0;
        human_move(4'd4);
        wait_cpu_req();
        vectors++; if (cpu_diff !== 2'd2) begin miscompares++; $display("FAIL diff3_map: got %0d want 2", cpu_diff); end
        cpu_ack = 1'b1; cpu_cell = 4'd0;
        #2;
        rst = 1'b1;
        #1;
        $display("async reset: req %b board %h count %0d diff %0d", cpu_req, board, mcount, cpu_diff);
        vectors++; if (cpu_req !== 1'b0 || board !== 18'h2AAAA) begin miscompares++; $display("FAIL arst_now: got req %b board %h want 0 2aaaa", cpu_req, board); end
        vectors++; if (mcount !== 4'd0 || cpu_diff !== 2'd0 || winner !== 2'd2) begin miscompares++; $display("FAIL arst_regs: got count %0d diff %0d winner %0d want 0 0 2", mcount, cpu_diff, winner); end
        @(negedge clk);
        rst = 1'b0; cpu_ack = 1'b0;
        tick();
        vectors++; if (cpu_req !== 1'b0 || pready !== 1'b0 || board !== 18'h2AAAA) begin miscompares++; $display("FAIL arst_idle: got req %b ready %b board %h want 0 0 2aaaa", cpu_req, pready, board); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_ignored_inputs();
        test_human_win();
        test_illegal_human();
        test_draw();
        test_cpu_wait();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
